// File: rtl/vc_egress_scheduler_pkg.sv
// Shared types and widths for the per-class egress scheduler.
package vc_egress_scheduler_pkg;

    localparam int unsigned NUM_CLASS   = 4;
    localparam int unsigned CLASS_W     = 2;
    localparam int unsigned PAYLOAD_W   = 12;
    localparam int unsigned OUT_W       = 16;
    localparam int unsigned SEQ_FIELD_W = OUT_W - CLASS_W - PAYLOAD_W;
    localparam int unsigned CREDIT_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CAPT = 2'd2,
        ST_SEND = 2'd3
    } state_e;

    typedef struct packed {
        logic [CLASS_W-1:0]     cls;
        logic [SEQ_FIELD_W-1:0] seq;
        logic [PAYLOAD_W-1:0]   payload;
    } out_word_t;

endpackage

// File: rtl/vc_egress_scheduler_if.sv
// Link-layer valid/ready word channel out of the egress scheduler.
interface vc_egress_scheduler_if;
    import vc_egress_scheduler_pkg::*;

    out_word_t out_data;
    logic      out_valid;
    logic      out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/vc_egress_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin pick: first requester at or after ptr.
module rr_arbiter4
    import vc_egress_scheduler_pkg::*;
(
    input  logic [NUM_CLASS-1:0] req,
    input  logic [CLASS_W-1:0]   ptr,
    output logic [CLASS_W-1:0]   gnt_idx,
    output logic                 any
);

    logic [CLASS_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_idx = ptr;
        any     = |req;
        idx     = ptr;
        for (int i = NUM_CLASS - 1; i >= 0; i--) begin
            idx = ptr + CLASS_W'(i);
            if (req[idx]) gnt_idx = idx;
        end
    end

endmodule

// File: rtl/vc_egress_scheduler.sv
// Drains four per-class FIFOs round-robin under link credit and emits
// tagged words {class, seq, payload} over a valid/ready channel.
module vc_egress_scheduler
    import vc_egress_scheduler_pkg::*;
#(
    parameter int unsigned CREDIT_MAX = 4,
    parameter int unsigned SEQ_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [NUM_CLASS-1:0]  fifo_empty,
    input  logic [PAYLOAD_W-1:0]  fifo_data0,
    input  logic [PAYLOAD_W-1:0]  fifo_data1,
    input  logic [PAYLOAD_W-1:0]  fifo_data2,
    input  logic [PAYLOAD_W-1:0]  fifo_data3,
    output logic [NUM_CLASS-1:0]  fifo_pop,
    input  logic [NUM_CLASS-1:0]  credit_return,
    vc_egress_scheduler_if.master link,
    output logic                  credit_err,
    output logic                  idle
);

    localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(CREDIT_MAX);

    state_e               state_q;
    state_e               state_nxt;
    logic [CLASS_W-1:0]   grant_q;
    logic [CLASS_W-1:0]   rr_q;
    logic [CLASS_W-1:0]   arb_idx;
    logic                 arb_any;
    logic [SEQ_W-1:0]     seq_q;
    logic [NUM_CLASS-1:0] eligible;
    logic [NUM_CLASS-1:0] credit_ovf;
    logic [PAYLOAD_W-1:0] fifo_data [NUM_CLASS];

    assign fifo_data[0] = fifo_data0;
    assign fifo_data[1] = fifo_data1;
    assign fifo_data[2] = fifo_data2;
    assign fifo_data[3] = fifo_data3;

    // Per-class credit counter; a same-cycle take and return cancel out.
    for (genvar n = 0; n < NUM_CLASS; n++) begin : g_credit
        logic [CREDIT_W-1:0] credit_q;
        logic                dec;
        logic                inc;

        assign dec           = (state_q == ST_POP) && (grant_q == CLASS_W'(n));
        assign inc           = credit_return[n];
        assign eligible[n]   = !fifo_empty[n] && (credit_q != '0);
        assign credit_ovf[n] = inc && !dec && (credit_q == CMAX);

        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                credit_q <= CMAX;
            end else if (dec && !inc) begin
                credit_q <= credit_q - CREDIT_W'(1);
            end else if (inc && !dec && (credit_q != CMAX)) begin
                credit_q <= credit_q + CREDIT_W'(1);
            end
        end
    end

    rr_arbiter4 u_arb (
        .req     (eligible),
        .ptr     (rr_q),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (arb_any) state_nxt = ST_POP;
            ST_POP:  state_nxt = ST_CAPT;
            ST_CAPT: state_nxt = ST_SEND;
            ST_SEND: if (link.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant is committed in IDLE; FIFO state is not rechecked afterwards.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            rr_q           <= '0;
            seq_q          <= '0;
            fifo_pop       <= '0;
            link.out_data  <= '0;
            link.out_valid <= 1'b0;
            credit_err     <= 1'b0;
            idle           <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            fifo_pop <= '0;
            idle     <= (state_nxt == ST_IDLE) && (&fifo_empty);
            if (|credit_ovf) credit_err <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_q  <= arb_idx;
                        fifo_pop <= NUM_CLASS'(1) << arb_idx;
                    end
                end
                ST_CAPT: begin
                    link.out_data  <= '{cls:     grant_q,
                                       seq:     SEQ_FIELD_W'(seq_q),
                                       payload: fifo_data[grant_q]};
                    link.out_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (link.out_ready) begin
                        link.out_valid <= 1'b0;
                        seq_q          <= seq_q + SEQ_W'(1);
                        rr_q           <= grant_q + CLASS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vc_egress_scheduler.sv
// Directed plus randomized bench for vc_egress_scheduler with a
// transaction-level FIFO/credit/arbitration reference model.
module tb_vc_egress_scheduler;
    import vc_egress_scheduler_pkg::*;

    localparam int CMAX = 4;

    logic        clk = 1'b0;
    logic        reset_L = 1'b1;
    logic [3:0]  fifo_empty = 4'hF;
    logic [3:0]  fifo_pop;
    logic [3:0]  credit_return = 4'h0;
    logic [11:0] fd [4];
    logic        credit_err;
    logic        idle;

    vc_egress_scheduler_if link();

    vc_egress_scheduler #(.CREDIT_MAX(CMAX), .SEQ_W(2)) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .fifo_empty    (fifo_empty),
        .fifo_data0    (fd[0]),
        .fifo_data1    (fd[1]),
        .fifo_data2    (fd[2]),
        .fifo_data3    (fd[3]),
        .fifo_pop      (fifo_pop),
        .credit_return (credit_return),
        .link          (link),
        .credit_err    (credit_err),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model state
    logic [11:0] q [4][$];
    int          m_credit [4];
    int          m_seq;
    int          m_rr;
    bit          m_err;
    logic [1:0]  exp_cls;
    logic [11:0] exp_pay;
    bit          have_exp;
    int          words;
    int          last_acc;
    int          gap;
    logic [1:0]  acc_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] el, input int rr);
        for (int i = 0; i < 4; i++) if (el[(rr + i) % 4]) return (rr + i) % 4;
        return -1;
    endfunction

    task automatic update_empty();
        for (int n = 0; n < 4; n++) fifo_empty[n] = (q[n].size() == 0);
    endtask

    task automatic push(input int n, input logic [11:0] v);
        q[n].push_back(v);
        update_empty();
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_credit[n] = CMAX;
            q[n].delete();
        end
        m_seq = 0; m_rr = 0; m_err = 1'b0; have_exp = 1'b0;
        update_empty();
    endtask

    // One clock: snapshot pre-edge view, advance the model, check post-edge outputs.
    task automatic tick();
        logic [3:0]  pop_p, ret_p, el_p, exp_pop;
        logic        acc_p, stall_p;
        logic [15:0] data_p, od;
        int          rr_p, p;
        pop_p   = fifo_pop;
        ret_p   = credit_return;
        acc_p   = link.out_valid && link.out_ready;
        stall_p = link.out_valid && !link.out_ready;
        data_p  = link.out_data;
        rr_p    = m_rr;
        for (int n = 0; n < 4; n++) el_p[n] = (q[n].size() != 0) && (m_credit[n] != 0);
        @(posedge clk);
        #1;
        cyc++;
        credit_return = 4'h0;
        for (int n = 0; n < 4; n++) begin
            if (pop_p[n] && !ret_p[n]) m_credit[n]--;
            else if (ret_p[n] && !pop_p[n]) begin
                if (m_credit[n] == CMAX) m_err = 1'b1;
                else m_credit[n]++;
            end
            if (pop_p[n] && q[n].size() > 0) begin
                fd[n]    = q[n].pop_front();
                exp_pay  = fd[n];
                exp_cls  = 2'(n);
                have_exp = 1'b1;
            end
        end
        update_empty();
        if (acc_p) begin
            chk("word_pending", 32'(have_exp), 32'd1);
            chk("word", 32'(data_p), 32'({exp_cls, 2'(m_seq), exp_pay}));
            acc_log.push_back(exp_cls);
            m_seq    = (m_seq + 1) % 4;
            m_rr     = (int'(exp_cls) + 1) % 4;
            have_exp = 1'b0;
            words++;
            gap      = cyc - last_acc;
            last_acc = cyc;
        end
        if (stall_p) begin
            od = link.out_data;
            chk("hold_valid", 32'(link.out_valid), 32'd1);
            chk("hold_data", 32'(od), 32'(data_p));
        end
        chk("credit_err", 32'(credit_err), 32'(m_err));
        if (fifo_pop != 4'h0) begin
            p       = pick(el_p, rr_p);
            exp_pop = (p < 0) ? 4'h0 : (4'h1 << p);
            chk("pop_class", 32'(fifo_pop), 32'(exp_pop));
            chk("pop_back_to_back", 32'(pop_p), 32'd0);
            chk("pop_while_valid", 32'(link.out_valid), 32'd0);
        end
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (words < target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(words >= target), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!link.out_valid && k < 30) begin
            tick();
            k++;
        end
        chk(tag, 32'(link.out_valid), 32'd1);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        int          n, w0;
        logic [3:0]  saw_pop;
        logic [15:0] first_data, od;
        logic [9:0]  order;

        for (int i = 0; i < 4; i++) fd[i] = 12'h0;
        link.out_ready = 1'b0;
        words = 0; last_acc = -100; gap = 0;
        model_reset();
        #2 reset_L = 1'b0;
        #10;
        od = link.out_data;
        chk("rst_pop", 32'(fifo_pop), 32'd0);
        chk("rst_valid", 32'(link.out_valid), 32'd0);
        chk("rst_data", 32'(od), 32'd0);
        chk("rst_err", 32'(credit_err), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        // 1: single class, latency and tag
        link.out_ready = 1'b1;
        tick(); tick();
        chk("t1_idle", 32'(idle), 32'd1);
        push(2, 12'hABC);
        n = 0; saw_pop = 4'h0;
        do begin
            tick();
            n++;
            if (fifo_pop != 4'h0) saw_pop = fifo_pop;
        end while (!link.out_valid && n < 20);
        first_data = link.out_data;
        chk("t1_latency", 32'(n), 32'd3);
        chk("t1_pop", 32'(saw_pop), 32'h4);
        chk("t1_data", 32'(first_data), 32'h8ABC);
        run_until(1, 10, "t1_done");
        chk("t1_credit2", 32'(dut.g_credit[2].credit_q), 32'd3);

        // 2: all classes, round-robin order at peak rate
        do_reset();
        acc_log.delete();
        w0 = words;
        for (int c = 0; c < 4; c++) push(c, 12'(12'h100 * c + 1));
        push(0, 12'h555);
        run_until(w0 + 5, 60, "t2_done");
        order = {acc_log[0], acc_log[1], acc_log[2], acc_log[3], acc_log[4]};
        chk("t2_order", 32'(order), 32'(10'b00_01_10_11_00));
        chk("t2_gap", 32'(gap), 32'd4);

        // 3: credit exhaustion on class 1, then one return
        do_reset();
        w0 = words;
        for (int i = 0; i < 6; i++) push(1, 12'($urandom));
        run_until(w0 + 4, 60, "t3_four");
        repeat (20) tick();
        chk("t3_blocked", 32'(words), 32'(w0 + 4));
        credit_return = 4'b0010;
        tick();
        run_until(w0 + 5, 30, "t3_return");
        repeat (20) tick();
        chk("t3_one_more", 32'(words), 32'(w0 + 5));

        // 4: back-pressure in SEND
        do_reset();
        w0 = words;
        link.out_ready = 1'b0;
        push(3, 12'h3C3);
        push(3, 12'h3D4);
        wait_valid("t4_valid");
        repeat (5) begin
            tick();
            chk("t4_no_pop", 32'(fifo_pop), 32'd0);
        end
        chk("t4_held", 32'(words), 32'(w0));
        link.out_ready = 1'b1;
        tick();
        chk("t4_accept_once", 32'(words), 32'(w0 + 1));
        run_until(w0 + 2, 20, "t4_next");

        // 5: return coinciding with POP, then return at max
        do_reset();
        w0 = words;
        push(0, 12'h0F0);
        n = 0;
        while (fifo_pop != 4'b0001 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_pop_seen", 32'(fifo_pop), 32'h1);
        credit_return = 4'b0001;
        tick();
        chk("t5_no_err_on_pop", 32'(credit_err), 32'd0);
        run_until(w0 + 1, 20, "t5_first");
        credit_return = 4'b0001;
        tick();
        chk("t5_err_set", 32'(credit_err), 32'd1);
        repeat (5) tick();
        chk("t5_err_sticky", 32'(credit_err), 32'd1);
        for (int i = 0; i < 6; i++) push(0, 12'($urandom));
        run_until(w0 + 5, 60, "t5_four");
        repeat (20) tick();
        chk("t5_credit_kept", 32'(words), 32'(w0 + 5));

        // 6: reset while a word waits in SEND
        do_reset();
        link.out_ready = 1'b0;
        push(2, 12'h777);
        wait_valid("t6_valid");
        reset_L = 1'b0;
        #1;
        chk("t6_async_valid", 32'(link.out_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        link.out_ready = 1'b1;
        tick(); tick(); tick();
        chk("t6_idle", 32'(idle), 32'd1);
        chk("t6_err", 32'(credit_err), 32'd0);
        chk("t6_cr0", 32'(dut.g_credit[0].credit_q), 32'd4);
        chk("t6_cr1", 32'(dut.g_credit[1].credit_q), 32'd4);
        chk("t6_cr2", 32'(dut.g_credit[2].credit_q), 32'd4);
        chk("t6_cr3", 32'(dut.g_credit[3].credit_q), 32'd4);

        // Randomized traffic, back-pressure and credit returns
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(3) == 0) begin
                n = int'($urandom_range(3));
                if (q[n].size() < 8) push(n, 12'($urandom));
            end
            link.out_ready = ($urandom_range(3) != 0);
            for (int c = 0; c < 4; c++) begin
                if (m_credit[c] < CMAX && $urandom_range(4) == 0) credit_return[c] = 1'b1;
                else if ($urandom_range(499) == 0) credit_return[c] = 1'b1;
            end
            tick();
        end

        // Drain with returns keeping up, then expect idle
        link.out_ready = 1'b1;
        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0
                || link.out_valid || have_exp) && n < 2000) begin
            for (int c = 0; c < 4; c++)
                if (m_credit[c] < CMAX && $urandom_range(2) == 0) credit_return[c] = 1'b1;
            tick();
            n++;
        end
        chk("drain_done", 32'(n < 2000), 32'd1);
        tick(); tick(); tick();
        chk("drain_idle", 32'(idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
